// File: rtl/bk_sector_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------------+
// | bk_sector_ctrl: backup-RAM save/load sequencer, 2^SECT_BITS x 512-byte sectors |
// | Optional macro BK_DIRTY_MAP_EN: per-sector dirty map, saves skip clean sectors |
// | Revision: 1.0                                                                  |
// +--------------------------------------------------------------------------------+
module bk_sector_ctrl #(
  parameter int          SECT_BITS = 6,
  parameter logic [31:0] LBA_BASE  = 32'd0
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   bk_ena,
  input  logic                   img_nonempty,
  input  logic                   dl_done,
  input  logic                   load_req,
  input  logic                   save_req,
  input  logic                   autosave_en,
  input  logic                   osd_status,
  input  logic                   nv_we,
  input  logic [SECT_BITS+8:0]   nv_addr,
  output logic [31:0]            sd_lba,
  output logic                   sd_rd,
  output logic                   sd_wr,
  input  logic                   sd_ack,
  output logic [SECT_BITS-1:0]   sect_idx,
  output logic                   busy,
  output logic                   loading,
  output logic                   pending
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_NEXT = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [SECT_BITS-1:0] sect_q, sect_d;
  logic                 rd_q, rd_d, wr_q, wr_d;
  logic                 busy_q, busy_d, loading_q, loading_d;
  logic                 pending_q, pending_d, is_load_q, is_load_d;
  logic                 old_load_q, old_load_d, old_save_q, old_save_d;
  logic                 old_auto_q, old_auto_d, ack_q, ack_d;

  logic                 load_lvl, save_lvl, auto_lvl;
  logic                 ack_rise, ack_fall;
  logic                 start_load, start_save;
  logic [SECT_BITS-1:0] save_first, save_next;
  logic                 save_any, save_last;

`ifdef BK_DIRTY_MAP_EN
  localparam int NSECT = 1 << SECT_BITS;

  logic [NSECT-1:0]     map_q, map_d;
  logic [SECT_BITS-1:0] we_sect;
  logic                 unused_nv_addr_lo;

  assign we_sect           = nv_addr[SECT_BITS+8:9];
  assign unused_nv_addr_lo = ^nv_addr[8:0];

  // Lowest dirty sector overall, and lowest dirty sector above the current one.
  always_comb begin
    save_first = '0;
    save_any   = 1'b0;
    save_next  = sect_q;
    save_last  = 1'b1;
    for (int i = NSECT - 1; i >= 0; i--) begin
      if (map_q[i]) begin
        save_first = SECT_BITS'(i);
        save_any   = 1'b1;
      end
      if (map_q[i] && (SECT_BITS'(i) > sect_q)) begin
        save_next = SECT_BITS'(i);
        save_last = 1'b0;
      end
    end
  end

  // Clears are applied before sets so a coincident write keeps its sector dirty.
  always_comb begin
    map_d = map_q;
    if (state_q == ST_XFER && ack_fall) begin
      if (is_load_q) begin
        if (&sect_q) map_d = '0;
      end else begin
        map_d[sect_q] = 1'b0;
      end
    end
    if (nv_we) map_d[we_sect] = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) map_q <= '0;
    else       map_q <= map_d;
  end
`else
  logic unused_nv_addr;

  assign unused_nv_addr = ^nv_addr;
  assign save_first     = '0;
  assign save_any       = 1'b1;
  assign save_next      = sect_q + SECT_BITS'(1);
  assign save_last      = &sect_q;
`endif

  assign load_lvl   = load_req & bk_ena;
  assign save_lvl   = save_req & bk_ena;
  assign auto_lvl   = pending_q & osd_status & autosave_en & bk_ena;
  assign ack_rise   = sd_ack & ~ack_q;
  assign ack_fall   = ~sd_ack & ack_q;
  assign start_load = (dl_done & bk_ena & img_nonempty) | (load_lvl & ~old_load_q);
  assign start_save = (save_lvl & ~old_save_q) | (auto_lvl & ~old_auto_q);

  always_comb begin
    state_d    = state_q;
    sect_d     = sect_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    busy_d     = busy_q;
    loading_d  = loading_q;
    is_load_d  = is_load_q;
    pending_d  = pending_q;
    old_load_d = load_lvl;
    old_save_d = save_lvl;
    old_auto_d = auto_lvl;
    ack_d      = sd_ack;

    case (state_q)
      ST_IDLE: begin
        busy_d    = 1'b0;
        loading_d = 1'b0;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        if (start_load) begin
          state_d   = ST_REQ;
          busy_d    = 1'b1;
          loading_d = 1'b1;
          is_load_d = 1'b1;
          sect_d    = '0;
          rd_d      = 1'b1;
        end else if (start_save) begin
          // With nothing dirty the save stays in IDLE: busy shows for one cycle only.
          busy_d    = 1'b1;
          is_load_d = 1'b0;
          sect_d    = save_first;
          pending_d = 1'b0;
          if (save_any) begin
            state_d = ST_REQ;
            wr_d    = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (ack_rise) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (ack_fall) begin
          if (is_load_q ? (&sect_q) : save_last) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            loading_d = 1'b0;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        sect_d  = is_load_q ? (sect_q + SECT_BITS'(1)) : save_next;
        rd_d    = is_load_q;
        wr_d    = ~is_load_q;
        state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase

    if (nv_we & bk_ena & ~osd_status) pending_d = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sect_q     <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      loading_q  <= 1'b0;
      is_load_q  <= 1'b0;
      pending_q  <= 1'b0;
      old_load_q <= 1'b0;
      old_save_q <= 1'b0;
      old_auto_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sect_q     <= sect_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      loading_q  <= loading_d;
      is_load_q  <= is_load_d;
      pending_q  <= pending_d;
      old_load_q <= old_load_d;
      old_save_q <= old_save_d;
      old_auto_q <= old_auto_d;
      ack_q      <= ack_d;
    end
  end

  assign sd_lba   = LBA_BASE + 32'(sect_q);
  assign sd_rd    = rd_q;
  assign sd_wr    = wr_q;
  assign sect_idx = sect_q;
  assign busy     = busy_q;
  assign loading  = loading_q;
  assign pending  = pending_q;

endmodule
`default_nettype wire

// File: doc/bk_sector_ctrl.md
Name: bk_sector_ctrl

Overview:
- Parametrised backup-RAM (NVRAM) save/load sequencer between the on-chip NVRAM dual-port and the HPS SD sector interface.
- Transfers 2^SECT_BITS sectors of 512 bytes, one SD request per sector.
- Handles manual load/save, automatic load at the end of a cartridge download, and autosave when the OSD opens.
- Successor to the fixed 64-sector inline sequencer: sector count is a parameter, requests are prioritised, and dirty-sector tracking is optional.

Parameters:
- SECT_BITS, 6: log2 of the sector count (6 = 64 sectors = 32 KB).
- LBA_BASE, 0: first SD LBA of the save image.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- bk_ena  in  1  writable save image mounted
- img_nonempty  in  1  save image size is nonzero
- dl_done  in  1  one-cycle pulse at the end of a cartridge download
- load_req  in  1  level, from the OSD load item
- save_req  in  1  level, from the OSD save item
- autosave_en  in  1  autosave option
- osd_status  in  1  OSD open
- nv_we  in  1  core write strobe to NVRAM
- nv_addr  in  SECT_BITS+9  core NVRAM write address
- sd_lba  out  32  sector address
- sd_rd  out  1  read request
- sd_wr  out  1  write request
- sd_ack  in  1  HPS acknowledge, high during the transfer
- sect_idx  out  SECT_BITS  current sector; drives the high bits of the NVRAM port-B address
- busy  out  1  transfer in progress
- loading  out  1  load in progress; held in core reset
- pending  out  1  unsaved NVRAM writes exist

Behaviour:
- Reset values: every output 0. sd_lba = LBA_BASE. The state machine enters IDLE.
- Reset mid-transfer: return to IDLE immediately. An sd_ack falling edge seen in IDLE is ignored.
- Edge detection: registered old_load = load_req&bk_ena and old_save = save_req&bk_ena. The autosave trigger is pending & osd_status & autosave_en & bk_ena, also edge-detected.
- Start priority (IDLE only), highest first:
  1. Auto-load: dl_done & bk_ena & img_nonempty.
  2. Load edge.
  3. Save edge or autosave edge.
  - Triggers arriving outside IDLE are dropped.
- States: IDLE -> REQ -> XFER -> NEXT -> REQ ... -> IDLE.
- IDLE -> REQ:
  - If the trigger is high at cycle N, then from cycle N+1: busy=1, loading=is_load, sect_idx=first sector, sd_lba=LBA_BASE+sect_idx.
  - sd_rd=is_load, sd_wr=~is_load.
- REQ -> XFER: on the sd_ack rising edge, deassert sd_rd and sd_wr in the next cycle.
- XFER: wait for the sd_ack falling edge.
  - If the sector is last, go to IDLE the next cycle with busy=0 and loading=0.
  - Otherwise go to NEXT.
- NEXT: advance sect_idx, update sd_lba, re-assert the request, go to REQ. That is one idle cycle between ack falling and the next request.
- Last sector: sect_idx == 2^SECT_BITS-1. sect_idx never wraps within a transfer.
- sd_lba = LBA_BASE + zero-extended sect_idx, 32-bit with wrap-around.
- pending:
  - Set on nv_we & bk_ena & ~osd_status.
  - Cleared in the cycle a save starts.
  - If set and clear coincide, set wins.
  - Loads do not touch pending.
- nv_we during a save is allowed.

Optional Feature:
- Macro: BK_DIRTY_MAP_EN.
- Defined:
  - Keep a 2^SECT_BITS dirty bitmap. nv_we sets bit nv_addr[SECT_BITS+8:9].
  - A save visits only dirty sectors, ascending. The first and next sector are found by priority search, with at most one cycle per advance.
  - A sector's bit clears on its write ack falling edge. A simultaneous nv_we to the same sector keeps it set.
  - A save with no dirty bits returns to IDLE one cycle after start with no SD request, and busy pulses 1 cycle.
  - A completed load clears the whole map.
  - Reset clears the map.
- Undefined:
  - No bitmap; a save writes every sector.
  - nv_addr is unused except for lint.

Test Plan:
- Auto-load:
  - Stimulus: bk_ena=1, img_nonempty=1, dl_done pulse; bench acks each request with a 4-cycle sd_ack.
  - Required: 64 sd_rd requests, LBA 0..63; loading=1 throughout; busy falls 1 cycle after the 64th ack falling edge.
- Manual save:
  - Stimulus: save_req rises.
  - Required: sd_wr=1 and sd_lba=0 the next cycle; sd_wr drops 1 cycle after ack rises; the next request comes 1 cycle after ack falls.
- Autosave:
  - Stimulus: nv_we with osd_status=0 (pending=1); then osd_status=1 with autosave_en=1.
  - Required: a save starts and pending clears.
  - Repeat with autosave_en=0: no save.
- Simultaneous triggers:
  - Stimulus: load_req and save_req rise in the same cycle.
  - Required: a load runs.
  - Also: save_req edge while busy is ignored; no second save after completion.
- Reset at sector 10:
  - Stimulus: reset at sector 10, then a stray sd_ack fall.
  - Required: outputs go to 0 and the stray ack fall has no effect.
  - After release, a new load starts at LBA 0.
- BK_DIRTY_MAP_EN:
  - Stimulus: writes to nv_addr 0x0200 and 0x7E00, then save.
  - Required: exactly two sd_wr requests, LBA 1 then 63.
  - A second save with no further writes issues zero requests.
